// File: rtl/result_writeback.sv
// Captures one group of CMAC/pool results into a shadow buffer and streams it word by word
// into the write-back FIFO, counting groups until the layer's expected total has been written.
module result_writeback #(
    parameter int PARA  = 16,
    parameter int DW    = 16,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_start,
    input  logic [2:0]           op_type,
    input  logic [CNT_W-1:0]     out_num,
    input  logic [PARA-1:0]      res_valid_0,
    input  logic [PARA-1:0]      res_valid_1,
    input  logic [PARA*DW-1:0]   result_0,
    input  logic [PARA*DW-1:0]   result_1,
    input  logic                 pool_valid,
    input  logic [DW-1:0]        pool_result,
    input  logic                 wb_fifo_full,
    output logic                 wb_fifo_wr_en,
    output logic [DW-1:0]        wb_fifo_din,
    output logic                 busy,
    output logic                 wb_done,
    output logic                 overflow
);

    localparam int NW = 2 * PARA;
    localparam int SW = $clog2(NW);
    localparam int IW = SW + 1;

    localparam logic [2:0] OP_CONV1 = 3'd1;
    localparam logic [2:0] OP_CONV3 = 3'd2;
    localparam logic [2:0] OP_CONVP = 3'd3;
    localparam logic [2:0] OP_APOOL = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   out_num_q;
    logic [CNT_W-1:0]   grp_cnt;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      n_words;
    logic [IW-1:0]      n_words_nx;
    logic [SW-1:0]      nxt_sel;
    logic [DW-1:0]      din_q;
    logic               overflow_q;
    logic               cap, cap_q, cap_edge;
    logic               start_ok, wr, last;
    logic [DW-1:0]      shadow    [NW];
    logic [DW-1:0]      cap_words [NW];

    assign start_ok = wb_start && (state != S_DRAIN);
    assign cap_edge = cap & ~cap_q;
    assign wr       = (state == S_DRAIN) && !wb_fifo_full;
    assign last     = (idx == n_words - IW'(1));
    assign nxt_sel  = idx[SW-1:0] + SW'(1);

    assign wb_fifo_wr_en = wr;
    assign wb_fifo_din   = din_q;
    assign busy          = (state == S_DRAIN);
    assign wb_done       = (state == S_DONE);
    assign overflow      = overflow_q;

    // Capture condition and the words a capture would take, both keyed on the latched op.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        cap        = 1'b0;
        n_words_nx = IW'(PARA);
        for (int i = 0; i < NW; i++) cap_words[i] = '0;
        case (op_q)
            OP_CONV1: begin
                cap = &res_valid_1;
                for (int i = 0; i < PARA; i++) cap_words[i] = result_1[i*DW +: DW];
            end
            OP_CONV3: begin
                cap = &res_valid_0;
                for (int i = 0; i < PARA; i++) cap_words[i] = result_0[i*DW +: DW];
            end
            OP_CONVP: begin
                cap        = (&res_valid_0) & (&res_valid_1);
                n_words_nx = IW'(NW);
                for (int i = 0; i < PARA; i++) begin
                    cap_words[i]        = result_0[i*DW +: DW];
                    cap_words[i + PARA] = result_1[i*DW +: DW];
                end
            end
            OP_APOOL: begin
                cap          = pool_valid;
                n_words_nx   = IW'(1);
                cap_words[0] = pool_result;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (start_ok) begin
            state_nx = (out_num == '0) ? S_DONE : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cap_edge) state_nx = S_DRAIN;
                S_DRAIN: if (wr && last)
                             state_nx = (grp_cnt + CNT_W'(1) == out_num_q) ? S_DONE : S_IDLE;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            out_num_q  <= '0;
            grp_cnt    <= '0;
            idx        <= '0;
            n_words    <= '0;
            din_q      <= '0;
            overflow_q <= 1'b0;
            cap_q      <= 1'b0;
            // NOTE: the shadow buffer is reset too, so din never exposes stale data after rst.
            for (int i = 0; i < NW; i++) shadow[i] <= '0;
        end else begin
            cap_q <= cap;
            if (start_ok) begin
                op_q       <= op_type;
                out_num_q  <= out_num;
                grp_cnt    <= '0;
                idx        <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (cap_edge && state != S_IDLE) overflow_q <= 1'b1;
                if (cap_edge && state == S_IDLE) begin
                    for (int i = 0; i < NW; i++) shadow[i] <= cap_words[i];
                    n_words <= n_words_nx;
                    idx     <= '0;
                    din_q   <= cap_words[0];
                end
                // Full holds idx and din, so the stalled word is presented again next cycle.
                if (wr) begin
                    idx   <= idx + IW'(1);
                    din_q <= shadow[nxt_sel];
                    if (last) grp_cnt <= grp_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: each step drives inputs after a clock edge and checks
// outputs and the logged FIFO writes against hand-computed values.
module tb_result_writeback;

    localparam int PARA  = 16;
    localparam int DW    = 16;
    localparam int CNT_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                wb_start;
    logic [2:0]          op_type;
    logic [CNT_W-1:0]    out_num;
    logic [PARA-1:0]     res_valid_0, res_valid_1;
    logic [PARA*DW-1:0]  result_0, result_1;
    logic                pool_valid;
    logic [DW-1:0]       pool_result;
    logic                wb_fifo_full;
    logic                wb_fifo_wr_en;
    logic [DW-1:0]       wb_fifo_din;
    logic                busy, wb_done, overflow;

    result_writeback #(.PARA(PARA), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_start      (wb_start),
        .op_type       (op_type),
        .out_num       (out_num),
        .res_valid_0   (res_valid_0),
        .res_valid_1   (res_valid_1),
        .result_0      (result_0),
        .result_1      (result_1),
        .pool_valid    (pool_valid),
        .pool_result   (pool_result),
        .wb_fifo_full  (wb_fifo_full),
        .wb_fifo_wr_en (wb_fifo_wr_en),
        .wb_fifo_din   (wb_fifo_din),
        .busy          (busy),
        .wb_done       (wb_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [15:0] wr_log [$];
    int          wr_cyc [$];
    int          n_vec  = 0;
    int          n_err  = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wb_fifo_wr_en === 1'b1) begin
            wr_log.push_back(wb_fifo_din);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [2:0] op, input logic [CNT_W-1:0] num);
        wb_start = 1'b1;
        op_type  = op;
        out_num  = num;
        tick();
        wb_start = 1'b0;
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic set_bank0(input logic [15:0] base);
        for (int i = 0; i < PARA; i++) result_0[i*DW +: DW] = base + 16'(i);
    endtask

    task automatic set_bank1(input logic [15:0] base);
        for (int i = 0; i < PARA; i++) result_1[i*DW +: DW] = base + 16'(i);
    endtask

    initial begin
        logic [15:0] exp_w;

        rst = 1'b1; wb_start = 1'b0; op_type = '0; out_num = '0;
        res_valid_0 = '0; res_valid_1 = '0; result_0 = '0; result_1 = '0;
        pool_valid = 1'b0; pool_result = '0; wb_fifo_full = 1'b0;
        #2;
        chk("rst_wr_en",    32'(wb_fifo_wr_en), 32'd0);
        chk("rst_din",      32'(wb_fifo_din),   32'd0);
        chk("rst_busy",     32'(busy),          32'd0);
        chk("rst_wb_done",  32'(wb_done),       32'd0);
        chk("rst_overflow", 32'(overflow),      32'd0);
        tick_n(2);
        rst = 1'b0;
        tick();

        // CONV3, one group, valid held high: captured once, 16 consecutive writes.
        start(3'd2, 1);
        chk("a_done_pre", 32'(wb_done), 32'd0);
        set_bank0(16'h3C00);
        res_valid_0 = '1;
        tick();
        chk("a_busy",  32'(busy),          32'd1);
        chk("a_wr_en", 32'(wb_fifo_wr_en), 32'd1);
        chk("a_din0",  32'(wb_fifo_din),   32'h3C00);
        tick_n(16);
        chk("a_done",     32'(wb_done),  32'd1);
        chk("a_busy_end", 32'(busy),     32'd0);
        chk("a_overflow", 32'(overflow), 32'd0);
        chk("a_count",    32'(wr_log.size()), 32'd16);
        for (int k = 0; k < 16 && k < wr_log.size(); k++) begin
            chk($sformatf("a_word%0d", k), 32'(wr_log[k]), 32'(16'h3C00 + 16'(k)));
            chk($sformatf("a_cyc%0d", k), 32'(wr_cyc[k] - wr_cyc[0]), 32'(k));
        end
        res_valid_0 = '0;
        tick();

        // CONVP, two groups of 32 words: bank0 lanes then bank1 lanes.
        start(3'd3, 2);
        chk("b_done_cleared", 32'(wb_done), 32'd0);
        set_bank0(16'h1000); set_bank1(16'h2000);
        res_valid_0 = '1; res_valid_1 = '1;
        tick();
        res_valid_0 = '0; res_valid_1 = '0;
        tick_n(32);
        chk("b_mid_busy", 32'(busy),    32'd0);
        chk("b_mid_done", 32'(wb_done), 32'd0);
        set_bank0(16'h3000); set_bank1(16'h4000);
        res_valid_0 = '1; res_valid_1 = '1;
        tick();
        res_valid_0 = '0; res_valid_1 = '0;
        tick_n(32);
        chk("b_done",  32'(wb_done), 32'd1);
        chk("b_count", 32'(wr_log.size()), 32'd64);
        for (int k = 0; k < 64 && k < wr_log.size(); k++) begin
            if (k < 32) exp_w = ((k % 32) < 16) ? 16'h1000 : 16'h2000;
            else        exp_w = ((k % 32) < 16) ? 16'h3000 : 16'h4000;
            exp_w = exp_w + 16'(k % 16);
            chk($sformatf("b_word%0d", k), 32'(wr_log[k]), 32'(exp_w));
        end

        // CONV1 with three cycles of FIFO full while lane 5 is presented.
        start(3'd1, 1);
        set_bank1(16'h5000);
        res_valid_1 = '1;
        tick();
        res_valid_1 = '0;
        tick_n(5);
        chk("c_din_pre", 32'(wb_fifo_din), 32'h5005);
        for (int j = 0; j < 3; j++) begin
            wb_fifo_full = 1'b1;
            #1;
            chk($sformatf("c_stall_wr%0d", j),  32'(wb_fifo_wr_en), 32'd0);
            chk($sformatf("c_stall_din%0d", j), 32'(wb_fifo_din),   32'h5005);
            tick();
        end
        wb_fifo_full = 1'b0;
        #1;
        chk("c_resume_wr",  32'(wb_fifo_wr_en), 32'd1);
        chk("c_resume_din", 32'(wb_fifo_din),   32'h5005);
        tick_n(11);
        chk("c_done",  32'(wb_done), 32'd1);
        chk("c_count", 32'(wr_log.size()), 32'd16);
        for (int k = 0; k < 16 && k < wr_log.size(); k++)
            chk($sformatf("c_word%0d", k), 32'(wr_log[k]), 32'(16'h5000 + 16'(k)));

        // APOOL, three single-word groups.
        start(3'd5, 3);
        for (int g = 0; g < 3; g++) begin
            pool_result = 16'h1111 * 16'(g + 1);
            pool_valid  = 1'b1;
            tick();
            pool_valid  = 1'b0;
            tick();
            if (g < 2) chk($sformatf("d_done_g%0d", g), 32'(wb_done), 32'd0);
        end
        chk("d_done",  32'(wb_done), 32'd1);
        chk("d_count", 32'(wr_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < wr_log.size(); k++)
            chk($sformatf("d_word%0d", k), 32'(wr_log[k]), 32'(16'h1111 * 16'(k + 1)));

        // CONV3 group arriving mid-drain is dropped and flagged.
        start(3'd2, 1);
        set_bank0(16'h6000);
        res_valid_0 = '1;
        tick();
        res_valid_0 = '0;
        tick_n(3);
        chk("e_ovf_pre", 32'(overflow), 32'd0);
        set_bank0(16'h7000);
        res_valid_0 = '1;
        tick();
        res_valid_0 = '0;
        chk("e_ovf",  32'(overflow), 32'd1);
        chk("e_busy", 32'(busy),     32'd1);
        tick_n(12);
        chk("e_done",     32'(wb_done),  32'd1);
        chk("e_ovf_held", 32'(overflow), 32'd1);
        chk("e_count",    32'(wr_log.size()), 32'd16);
        for (int k = 0; k < 16 && k < wr_log.size(); k++)
            chk($sformatf("e_word%0d", k), 32'(wr_log[k]), 32'(16'h6000 + 16'(k)));

        // Reset at the seventh write of a group, then an empty layer.
        start(3'd2, 1);
        set_bank0(16'h8000);
        res_valid_0 = '1;
        tick();
        res_valid_0 = '0;
        tick_n(6);
        chk("f_din_pre", 32'(wb_fifo_din), 32'h8006);
        rst = 1'b1;
        #1;
        chk("f_rst_wr",   32'(wb_fifo_wr_en), 32'd0);
        chk("f_rst_din",  32'(wb_fifo_din),   32'd0);
        chk("f_rst_busy", 32'(busy),          32'd0);
        chk("f_rst_done", 32'(wb_done),       32'd0);
        chk("f_rst_ovf",  32'(overflow),      32'd0);
        tick();
        rst = 1'b0;
        chk("f_count_rst", 32'(wr_log.size()), 32'd6);
        res_valid_0 = '1;
        tick_n(3);
        res_valid_0 = '0;
        chk("f_no_cap_busy", 32'(busy), 32'd0);
        chk("f_count_idle",  32'(wr_log.size()), 32'd6);
        start(3'd2, 0);
        chk("f_zero_done", 32'(wb_done), 32'd1);
        chk("f_zero_busy", 32'(busy),    32'd0);
        tick_n(3);
        chk("f_zero_writes", 32'(wr_log.size()), 32'd0);
        chk("f_zero_held",   32'(wb_done),       32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
